// File: rtl/channel_accumulator.sv
// Integrate-and-dump accumulator for one tracking channel: chip-signed I/Q products are
// summed with saturation over a code epoch and latched on dump behind a valid/ready readout.
module channel_accumulator #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 20,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    chan_en,
  input  logic                    sample_en,
  input  logic signed [IN_W-1:0]  sin_product,
  input  logic signed [IN_W-1:0]  cos_product,
  input  logic                    code_chip,
  input  logic                    dump,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_i,
  output logic signed [ACC_W-1:0] out_q,
  output logic [CNT_W-1:0]        out_cnt,
  output logic                    out_sat,
  output logic                    overrun
);

  localparam int SUM_W = ACC_W + 2;

  typedef logic signed [ACC_W:0]   term_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  typedef struct packed {
    acc_t val;
    logic clamped;
  } sat_res_t;

  localparam sum_t SUM_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam sum_t SUM_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Sign-extend one bit beyond the accumulator so negating the most negative input is exact.
  function automatic term_t make_term(input logic signed [IN_W-1:0] x, input logic neg);
    term_t ext;
    ext = {{(ACC_W+1-IN_W){x[IN_W-1]}}, x};
    return neg ? -ext : ext;
  endfunction

  function automatic sat_res_t sat_add(input acc_t acc, input term_t t);
    sum_t     s;
    sat_res_t r;
    s = sum_t'(acc) + sum_t'(t);
    if (s > SUM_MAX)      r = '{val: ACC_MAX, clamped: 1'b1};
    else if (s < SUM_MIN) r = '{val: ACC_MIN, clamped: 1'b1};
    else                  r = '{val: acc_t'(s), clamped: 1'b0};
    return r;
  endfunction

  acc_t             acc_i, acc_q;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  term_t            add_i, add_q;
  sat_res_t         nxt_i, nxt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clamp_any;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    add_i     = '0;
    add_q     = '0;
    if (sample_en) begin
      add_i = make_term(cos_product, code_chip);
      add_q = make_term(sin_product, code_chip);
    end
    nxt_i     = sat_add(acc_i, add_i);
    nxt_q     = sat_add(acc_q, add_q);
    cnt_nxt   = (sample_en && cnt != '1) ? cnt + 1'b1 : cnt;
    clamp_any = nxt_i.clamped | nxt_q.clamped;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (!chan_en) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
        sat   <= 1'b0;
      end else if (dump) begin
        // A sample arriving with the dump belongs to the epoch being closed.
        out_i     <= nxt_i.val;
        out_q     <= nxt_q.val;
        out_cnt   <= cnt_nxt;
        out_sat   <= sat | clamp_any;
        out_valid <= 1'b1;
        overrun   <= out_valid & ~out_ready;
        acc_i     <= '0;
        acc_q     <= '0;
        cnt       <= '0;
        sat       <= 1'b0;
      end else if (sample_en) begin
        acc_i <= nxt_i.val;
        acc_q <= nxt_q.val;
        cnt   <= cnt_nxt;
        sat   <= sat | clamp_any;
      end
    end
  end

endmodule

// File: tb/tb_channel_accumulator.sv
// Bench for channel_accumulator: a wide (ACC_W=20) and a narrow (ACC_W=8) instance share
// stimulus; an integer-arithmetic epoch model predicts every output after every clock.
module tb_channel_accumulator;

  localparam int IN_W = 5;
  localparam int CNT_W = 16;
  localparam longint CNT_MAX = (longint'(1) <<< CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic chan_en, sample_en, code_chip, dump, out_ready;
  logic signed [IN_W-1:0] sin_product, cos_product;

  logic               vw, ow, sw, vn, on, sn;
  logic signed [19:0] iw, qw;
  logic signed [7:0]  in_, qn;
  logic [CNT_W-1:0]   cw, cn;

  channel_accumulator #(.IN_W(IN_W), .ACC_W(20), .CNT_W(CNT_W)) dut_w (
    .clk(clk), .reset_n(reset_n), .chan_en(chan_en), .sample_en(sample_en),
    .sin_product(sin_product), .cos_product(cos_product), .code_chip(code_chip),
    .dump(dump), .out_ready(out_ready), .out_valid(vw), .out_i(iw), .out_q(qw),
    .out_cnt(cw), .out_sat(sw), .overrun(ow));

  channel_accumulator #(.IN_W(IN_W), .ACC_W(8), .CNT_W(CNT_W)) dut_n (
    .clk(clk), .reset_n(reset_n), .chan_en(chan_en), .sample_en(sample_en),
    .sin_product(sin_product), .cos_product(cos_product), .code_chip(code_chip),
    .dump(dump), .out_ready(out_ready), .out_valid(vn), .out_i(in_), .out_q(qn),
    .out_cnt(cn), .out_sat(sn), .overrun(on));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: index 0 is the 20-bit instance, index 1 the 8-bit one.
  int     acc_w [2] = '{20, 8};
  longint m_acc_i [2], m_acc_q [2], m_out_i [2], m_out_q [2];
  bit     m_sat [2], m_out_sat [2];
  longint m_cnt, m_out_cnt;
  bit     m_valid, m_ovr;

  function automatic longint clampw(input longint v, input int w);
    longint mx;
    mx = (longint'(1) <<< (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc_i[k] = 0; m_acc_q[k] = 0; m_out_i[k] = 0; m_out_q[k] = 0;
      m_sat[k] = 0; m_out_sat[k] = 0;
    end
    m_cnt = 0; m_out_cnt = 0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid_w"}, longint'(vw), longint'(m_valid));
    check({tag, ".valid_n"}, longint'(vn), longint'(m_valid));
    check({tag, ".ovr_w"},   longint'(ow), longint'(m_ovr));
    check({tag, ".ovr_n"},   longint'(on), longint'(m_ovr));
    check({tag, ".i_w"},     longint'(iw), m_out_i[0]);
    check({tag, ".q_w"},     longint'(qw), m_out_q[0]);
    check({tag, ".i_n"},     longint'(in_), m_out_i[1]);
    check({tag, ".q_n"},     longint'(qn), m_out_q[1]);
    check({tag, ".cnt_w"},   longint'(cw), m_out_cnt);
    check({tag, ".cnt_n"},   longint'(cn), m_out_cnt);
    check({tag, ".sat_w"},   longint'(sw), longint'(m_out_sat[0]));
    check({tag, ".sat_n"},   longint'(sn), longint'(m_out_sat[1]));
  endtask

  // One clock: drive inputs, advance the model by the epoch rules, clock, then compare.
  task automatic step(input string tag, input bit en, input bit se, input int s, input int c,
                      input bit chip, input bit dmp, input bit rdy);
    longint ti, tq, si, sq, ci, cq;
    bit     dump_now;
    chan_en = en; sample_en = se; sin_product = s[IN_W-1:0]; cos_product = c[IN_W-1:0];
    code_chip = chip; dump = dmp; out_ready = rdy;

    ti = se ? (chip ? -c : c) : 0;
    tq = se ? (chip ? -s : s) : 0;
    dump_now = en && dmp;
    m_ovr = dump_now && m_valid && !rdy;
    if (m_valid && rdy) m_valid = 0;
    for (int k = 0; k < 2; k++) begin
      si = m_acc_i[k] + ti; ci = clampw(si, acc_w[k]);
      sq = m_acc_q[k] + tq; cq = clampw(sq, acc_w[k]);
      if (!en) begin
        m_acc_i[k] = 0; m_acc_q[k] = 0; m_sat[k] = 0;
      end else if (dmp) begin
        m_out_i[k] = ci; m_out_q[k] = cq;
        m_out_sat[k] = m_sat[k] || (si != ci) || (sq != cq);
        m_acc_i[k] = 0; m_acc_q[k] = 0; m_sat[k] = 0;
      end else if (se) begin
        m_acc_i[k] = ci; m_acc_q[k] = cq;
        m_sat[k] = m_sat[k] || (si != ci) || (sq != cq);
      end
    end
    if (!en) m_cnt = 0;
    else if (dmp) begin
      m_out_cnt = (m_cnt + se > CNT_MAX) ? CNT_MAX : m_cnt + se;
      m_valid = 1;
      m_cnt = 0;
    end else if (se) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;

    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    chan_en = 0; sample_en = 0; sin_product = '0; cos_product = '0;
    code_chip = 0; dump = 0; out_ready = 0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    // Plain sum: cos=3, sin=-2 for 10 samples.
    for (int n = 0; n < 10; n++) step("sum_acc", 1, 1, -2, 3, 0, 0, 0);
    step("sum_dump", 1, 0, 0, 0, 0, 1, 0);
    check("sum_i_literal", longint'(iw), 30);
    check("sum_q_literal", longint'(qw), -20);
    check("sum_cnt_literal", longint'(cw), 10);
    step("sum_drain", 1, 0, 0, 0, 0, 0, 1);

    // Chip sign handling.
    for (int n = 0; n < 8; n++) step("alt_acc", 1, 1, 0, 9, n[0], 0, 0);
    step("alt_dump", 1, 0, 0, 0, 0, 1, 1);
    check("alt_i_literal", longint'(iw), 0);
    for (int n = 0; n < 4; n++) step("neg_acc", 1, 1, -9, 0, 1, 0, 1);
    step("neg_dump", 1, 0, 0, 0, 0, 1, 1);
    check("neg_q_literal", longint'(qw), 36);
    step("min_in", 1, 1, -16, -16, 1, 1, 1);

    // Sample coinciding with dump closes the current epoch.
    for (int n = 0; n < 4; n++) step("bnd_acc", 1, 1, 0, 1, 0, 0, 1);
    step("bnd_dump", 1, 1, 0, 1, 0, 1, 1);
    check("bnd_i_literal", longint'(iw), 5);
    check("bnd_cnt_literal", longint'(cw), 5);
    step("bnd_fresh", 1, 1, 0, 2, 0, 0, 1);
    step("bnd_fresh_dump", 1, 0, 0, 0, 0, 1, 1);

    // Saturation on the 8-bit instance, then a clean epoch.
    for (int n = 0; n < 20; n++) step("sat_acc", 1, 1, -9, 9, 0, 0, 1);
    step("sat_dump", 1, 0, 0, 0, 0, 1, 1);
    check("sat_i_literal", longint'(in_), 127);
    check("sat_q_literal", longint'(qn), -128);
    check("sat_flag_literal", longint'(sn), 1);
    step("nosat_acc", 1, 1, 1, 1, 0, 0, 1);
    step("nosat_dump", 1, 0, 0, 0, 0, 1, 1);
    check("nosat_flag_literal", longint'(sn), 0);
    step("drain", 1, 0, 0, 0, 0, 0, 1);

    // Overrun and consume-with-dump.
    step("ho_a", 1, 1, 0, 4, 0, 0, 0);
    step("ho_d1", 1, 0, 0, 0, 0, 1, 0);
    step("ho_b", 1, 1, 0, 7, 0, 0, 0);
    step("ho_d2", 1, 0, 0, 0, 0, 1, 0);
    check("ho_overrun_literal", longint'(ow), 1);
    check("ho_i_literal", longint'(iw), 7);
    step("ho_pulse_end", 1, 1, 0, 2, 0, 0, 0);
    step("ho_d3_ready", 1, 0, 0, 0, 0, 1, 1);
    check("ho_no_overrun", longint'(ow), 0);
    step("ho_hold", 1, 0, 0, 0, 0, 0, 0);

    // chan_en low ignores dump and samples but still drains.
    step("en_acc", 1, 1, 3, 3, 0, 0, 0);
    step("en_off_dump", 0, 1, 3, 3, 0, 1, 0);
    step("en_off_drain", 0, 1, 3, 3, 0, 1, 1);
    step("en_on_acc", 1, 1, 2, 5, 0, 0, 0);
    step("en_on_dump", 1, 0, 0, 0, 0, 1, 1);
    check("en_clean_i", longint'(iw), 5);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int rs, rc;
      rs = int'($urandom_range(0, 31)) - 16;
      rc = int'($urandom_range(0, 31)) - 16;
      step("rand", $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, rs, rc,
           1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-epoch with a pending result.
    step("rst_acc", 1, 1, 5, 5, 0, 0, 0);
    step("rst_dump", 1, 1, 5, 5, 0, 1, 0);
    step("rst_acc2", 1, 1, 5, 5, 0, 0, 0);
    idle_inputs();
    #2;
    reset_n = 0;
    model_reset();
    #1;
    compare_all("rst_async");
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    step("rst_after", 1, 0, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
